// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU/memory types: 32-bit word type, RAM handshake state
//             and the default timing/geometry of the backing RAM.
//  Contents : word_t, ramstate_t, RAM_LAT_DEFAULT, RAM_DEPTH_W_DEFAULT,
//             ram_key_t (request identity used to detect new requests).
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   localparam int RAM_LAT_DEFAULT     = 2;
   localparam int RAM_DEPTH_W_DEFAULT = 14;

   // {ren, wen, byte address}: store data is deliberately not part of the
   // identity, so a write whose data changes is still the same request.
   typedef logic [33:0] ram_key_t;

   function automatic ram_key_t make_key(input logic ren, input logic wen,
                                         input word_t addr);
      return {ren, wen, addr};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_if
//  Purpose  : RAM request bus between the memory controller (master) and the
//             backing RAM (slave).
//  Signals  : ramREN, ramWEN   read / write request, held until ACCESS
//             ramaddr          byte address
//             ramstore         write data
//             ramload          read data (valid only in ACCESS of a read)
//             ramstate         FREE / BUSY / ACCESS / ERROR handshake
//  Revision : 1.0  initial release
// ============================================================================
interface ram_if;
   import cpu_types_pkg::*;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport master (
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate
   );

   modport slave (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );

endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl_array.sv
`default_nettype none
// ============================================================================
//  Module   : ram_array
//  Purpose  : Word storage for the backing RAM. One synchronous write port,
//             one asynchronous read port sharing the same index. Contents are
//             not cleared by reset.
//  Ports    : CLK      clock, rising edge
//             i_we     write enable
//             i_index  word index
//             i_wdata  write data
//             o_rdata  read data at i_index (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module ram_array
   import cpu_types_pkg::*;
#(
   parameter int DEPTH_W = RAM_DEPTH_W_DEFAULT
) (
   input  wire logic               CLK,
   input  wire logic               i_we,
   input  wire logic [DEPTH_W-1:0] i_index,
   input  wire word_t              i_wdata,
   output      word_t              o_rdata
);

   word_t r_mem [2**DEPTH_W];

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_index] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_index];

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_access_ctrl
//  Purpose  : Backing RAM with programmable access latency behind the memory
//             controller. A request with a stable key sees LAT BUSY cycles and
//             then one ACCESS cycle; reads return data in ACCESS, writes
//             commit at the clock edge that closes ACCESS.
//  Ports    : CLK    clock, rising edge
//             RST    synchronous active-high reset
//             ramif  ram_if.slave request bus
//  Params   : LAT      wait cycles before ACCESS (1..15)
//             DEPTH_W  log2 of array depth in 32-bit words
//  Macro    : RAM_BOUNDS_CHECK_EN - when defined, REN&WEN or an address above
//             the array raises ERROR; when undefined the address wraps and
//             WEN wins over REN.
//  Revision : 1.0  initial release
// ============================================================================
module ram_access_ctrl
   import cpu_types_pkg::*;
#(
   parameter int LAT     = RAM_LAT_DEFAULT,
   parameter int DEPTH_W = RAM_DEPTH_W_DEFAULT
) (
   input wire logic CLK,
   input wire logic RST,
   ram_if.slave     ramif
);

   localparam logic [3:0] c_lat = 4'(LAT);

   logic [3:0]         r_cnt;
   ram_key_t           r_prev_key;

   ram_key_t           w_key;
   logic               w_req;
   logic               w_err;
   logic               w_is_read;
   logic               w_is_write;
   logic               w_we;
   logic [3:0]         w_cnt_nxt;
   ramstate_t          w_state;
   logic [DEPTH_W-1:0] w_index;
   word_t              w_rdata;

   assign w_key   = make_key(ramif.ramREN, ramif.ramWEN, ramif.ramaddr);
   assign w_req   = ramif.ramREN | ramif.ramWEN;
   assign w_index = ramif.ramaddr[DEPTH_W+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
   assign w_err = w_req &
                  ((ramif.ramREN & ramif.ramWEN) |
                   (ramif.ramaddr[31:DEPTH_W+2] != '0));
`else
   assign w_err = 1'b0;
`endif

   // WEN has priority so a simultaneous REN&WEN (only reachable without the
   // bounds check) behaves as a pure write.
   assign w_is_write = ramif.ramWEN;
   assign w_is_read  = ramif.ramREN & ~ramif.ramWEN;

   // FREE/BUSY/ERROR follow the live request; ACCESS only when the registered
   // count has reached LAT for an unchanged key.
   always_comb begin
      w_state   = FREE;
      w_cnt_nxt = 4'd1;
      if (w_err) begin
         w_state   = ERROR;
         w_cnt_nxt = 4'd0;
      end else if (!w_req) begin
         w_state   = FREE;
         w_cnt_nxt = 4'd1;
      end else if (w_key != r_prev_key) begin
         w_state   = BUSY;
         w_cnt_nxt = 4'd1;
      end else if (r_cnt >= c_lat) begin
         w_state   = ACCESS;
         w_cnt_nxt = 4'd0;
      end else begin
         w_state   = BUSY;
         w_cnt_nxt = r_cnt + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt      <= 4'd0;
         r_prev_key <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_prev_key <= w_key;
      end
   end

   // Reset in the same cycle wins over a pending commit.
   assign w_we = (w_state == ACCESS) & w_is_write & ~RST;

   ram_array #(
      .DEPTH_W (DEPTH_W)
   ) u_array (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_index (w_index),
      .i_wdata (ramif.ramstore),
      .o_rdata (w_rdata)
   );

   assign ramif.ramstate = w_state;
   assign ramif.ramload  = ((w_state == ACCESS) && w_is_read) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_access_ctrl
//  Purpose  : Directed self-checking bench for ram_access_ctrl. Three
//             instances (LAT = 1, 2, 15) share clock and reset; selector
//             values equal the instance latency.
//  Macro    : RAM_BOUNDS_CHECK_EN selects which out-of-range behaviour is
//             expected.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_access_ctrl;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   ram_if b1 ();
   ram_if b2 ();
   ram_if b15 ();

   ram_access_ctrl #(.LAT(1),  .DEPTH_W(14)) u_dut1  (.CLK(CLK), .RST(RST), .ramif(b1));
   ram_access_ctrl #(.LAT(2),  .DEPTH_W(14)) u_dut2  (.CLK(CLK), .RST(RST), .ramif(b2));
   ram_access_ctrl #(.LAT(15), .DEPTH_W(14)) u_dut15 (.CLK(CLK), .RST(RST), .ramif(b15));

   task automatic set_bus(input int s, input logic ren, input logic wen,
                          input word_t a, input word_t d);
      case (s)
         1:  begin b1.ramREN  = ren; b1.ramWEN  = wen; b1.ramaddr  = a; b1.ramstore  = d; end
         2:  begin b2.ramREN  = ren; b2.ramWEN  = wen; b2.ramaddr  = a; b2.ramstore  = d; end
         default: begin b15.ramREN = ren; b15.ramWEN = wen; b15.ramaddr = a; b15.ramstore = d; end
      endcase
   endtask

   // Inputs change on the falling edge, away from the active edge.
   task automatic drv(input int s, input logic ren, input logic wen,
                      input word_t a, input word_t d);
      @(negedge CLK);
      set_bus(s, ren, wen, a, d);
   endtask

   task automatic chk(input int s, input ramstate_t es, input word_t el,
                      input string tag);
      ramstate_t st;
      word_t     ld;
      #1;
      case (s)
         1:       begin st = b1.ramstate;  ld = b1.ramload;  end
         2:       begin st = b2.ramstate;  ld = b2.ramload;  end
         default: begin st = b15.ramstate; ld = b15.ramload; end
      endcase
      checks++;
      assert (st === es) else begin
         errors++;
         $error("FAIL %s ramstate observed=%0d expected=%0d", tag, st, es);
      end
      checks++;
      assert (ld === el) else begin
         errors++;
         $error("FAIL %s ramload observed=%h expected=%h", tag, ld, el);
      end
   endtask

   // Held request: s BUSY cycles (s == LAT of that instance), then ACCESS.
   task automatic op(input int s, input logic ren, input logic wen,
                     input word_t a, input word_t d, input word_t el,
                     input string tag);
      for (int i = 0; i < s; i++) begin
         drv(s, ren, wen, a, d);
         chk(s, BUSY, 32'h0, tag);
      end
      drv(s, ren, wen, a, d);
      chk(s, ACCESS, el, tag);
   endtask

   initial begin
      set_bus(1, 0, 0, 0, 0);
      set_bus(2, 0, 0, 0, 0);
      set_bus(15, 0, 0, 0, 0);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      drv(2, 0, 0, 0, 0);
      RST = 1'b0;
      chk(2,  FREE, 32'h0, "reset_l2");
      chk(1,  FREE, 32'h0, "reset_l1");
      chk(15, FREE, 32'h0, "reset_l15");

      // single write then read
      op(2, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0, "wr_100");
      op(2, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, "rd_100");

      // two-word writeback, address switched right after first ACCESS
      op(2, 0, 1, 32'h200, 32'h11111111, 32'h0, "wb_w0");
      op(2, 0, 1, 32'h204, 32'h22222222, 32'h0, "wb_w1");
      op(2, 1, 0, 32'h200, 32'h0, 32'h11111111, "rd_200");
      op(2, 1, 0, 32'h204, 32'h0, 32'h22222222, "rd_204");

      // abandoned read, then write restarts the count
      drv(2, 1, 0, 32'h300, 32'h0);
      chk(2, BUSY, 32'h0, "abandon_rd");
      op(2, 0, 1, 32'h300, 32'hAAAAAAAA, 32'h0, "wr_300");
      // abandoned write must not commit
      drv(2, 0, 1, 32'h300, 32'h55555555);
      chk(2, BUSY, 32'h0, "abandon_wr");
      op(2, 1, 0, 32'h300, 32'h0, 32'hAAAAAAAA, "rd_300");

      // reset during BUSY count aborts the write
      op(2, 0, 1, 32'h400, 32'h12345678, 32'h0, "wr_400_init");
      drv(2, 0, 1, 32'h400, 32'h5);
      chk(2, BUSY, 32'h0, "wr_400_busy");
      RST = 1'b1;
      drv(2, 0, 0, 32'h0, 32'h0);
      RST = 1'b0;
      chk(2, FREE, 32'h0, "after_rst");
      op(2, 1, 0, 32'h400, 32'h0, 32'h12345678, "rd_400_kept");
      drv(2, 0, 1, 32'h400, 32'h5);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk(2, BUSY, 32'h0, "reheld_b0");
      drv(2, 0, 1, 32'h400, 32'h5);
      chk(2, BUSY, 32'h0, "reheld_b1");
      drv(2, 0, 1, 32'h400, 32'h5);
      chk(2, ACCESS, 32'h0, "reheld_acc");
      op(2, 1, 0, 32'h400, 32'h0, 32'h5, "rd_400_new");

      // out-of-range / conflicting requests
      op(2, 0, 1, 32'h10, 32'h0BADF00D, 32'h0, "wr_10");
`ifdef RAM_BOUNDS_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         drv(2, 1, 0, 32'h8000_0000, 32'h0);
         chk(2, ERROR, 32'h0, "err_addr");
      end
      for (int i = 0; i < 3; i++) begin
         drv(2, 1, 1, 32'h10, 32'hFFFFFFFF);
         chk(2, ERROR, 32'h0, "err_renwen");
      end
      op(2, 1, 0, 32'h10, 32'h0, 32'h0BADF00D, "rd_10_kept");
`else
      op(2, 1, 0, 32'h8000_0010, 32'h0, 32'h0BADF00D, "alias_rd");
      op(2, 1, 1, 32'h10, 32'h00000077, 32'h0, "renwen_wr");
      op(2, 1, 0, 32'h10, 32'h0, 32'h00000077, "rd_10_wen_wins");
`endif
      drv(2, 0, 0, 0, 0);
      chk(2, FREE, 32'h0, "idle_l2");

      // latency sweeps on the same word
      op(1, 0, 1, 32'h40, 32'hCAFE0001, 32'h0, "l1_wr");
      op(1, 1, 0, 32'h40, 32'h0, 32'hCAFE0001, "l1_rd");
      op(15, 0, 1, 32'h40, 32'hCAFE000F, 32'h0, "l15_wr");
      op(15, 1, 0, 32'h40, 32'h0, 32'hCAFE000F, "l15_rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Word-addressed backing RAM with programmable access latency; it sits directly downstream of the coherence/arbitration memory controller and is the sole consumer of its ram request bus. It presents the `ramstate` handshake (FREE/BUSY/ACCESS/ERROR) that the controller's writeback, snoop-forward and read states wait on. It returns `ramload` for reads and commits `ramstore` for writes. The latency is configurable so controller and cache FSMs are exercised under both fast and slow memory.

## Interface
- `LAT`, default 2: wait cycles before ACCESS; legal range 1..15.
- `DEPTH_W`, default 14: log2 of array depth in 32-bit words (16K words).
- `CLK` in 1: single clock, rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `ramREN` in 1: read request, held until ACCESS.
- `ramWEN` in 1: write request, held until ACCESS.
- `ramaddr` in 32: byte address (`word_t`); word index = `ramaddr[DEPTH_W+1:2]`, bits [1:0] ignored.
- `ramstore` in 32: write data, sampled in the ACCESS cycle.
- `ramload` out 32: read data, valid only while `ramstate == ACCESS` for a read, 0 otherwise.
- `ramstate` out `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- Request = `ramREN | ramWEN`; request key = {`ramREN`, `ramWEN`, `ramaddr`}, registered every cycle as `prev_key`.
- Counter `cnt` (4 bits) tracks the current request:
  - no request, or key != `prev_key` (new/changed request): effective count 0, `ramstate` BUSY (FREE if no request), next `cnt` = 1;
  - request, key unchanged, `cnt < LAT`: `ramstate` BUSY, `cnt` increments;
  - `cnt == LAT`: `ramstate` ACCESS, next `cnt` = 0.
- A request held past ACCESS with the same key is a new access: BUSY again for LAT cycles, then ACCESS.
  - The controller's two-word sequences change address between words, so each word restarts the count.
- Read: in the ACCESS cycle, `ramload` = array[index] (combinational from the array).
- Write: array[index] <= `ramstore` at the clock edge closing the ACCESS cycle. No array write occurs in any other cycle.
- Request dropped or changed mid-count: the access is abandoned, no write, count restarts. This is not an error.
- ERROR (bounds check only): `ramREN & ramWEN`, or `ramaddr[31:DEPTH_W+2] != 0`.
  - ERROR persists while the condition holds; no read data, no write.
  - The counter is held at 0.
- Reset: `cnt` = 0, `prev_key` = 0, so `ramstate` is FREE (with no request) and `ramload` = 0 in the first cycle after reset. The array is not cleared.
- A reset asserted during a BUSY count aborts the access with no write. After reset, a held request counts from zero.

## Timing
- Request first presented in cycle t with stable key: BUSY in cycles t..t+LAT-1, ACCESS in t+LAT.
  - LAT=1: one BUSY cycle, then ACCESS.
- `ramstate`/`ramload` are Mealy on the request inputs for the FREE/BUSY/ERROR distinction. The ACCESS decision uses registered `cnt` only.
- Back-to-back requests: ACCESS in t+LAT, next key at t+LAT+1 reaches ACCESS at t+2·LAT+1.
- Read-after-write to the same word: the write commits at the end of its ACCESS cycle. A following read returns the new data.

## Configuration
- `RAM_BOUNDS_CHECK_EN` defined: the ERROR conditions above are active.
- `RAM_BOUNDS_CHECK_EN` undefined: ERROR is never driven.
  - Upper address bits are ignored, so the address wraps modulo depth.
  - `ramREN & ramWEN` is treated as a write: WEN wins, and `ramload` = 0.

## Structure
- `ramstate_t` and `word_t` remain in `cpu_types_pkg`.
- Add `RAM_LAT_DEFAULT` (= 2) and `RAM_DEPTH_W_DEFAULT` (= 14) constants to `cpu_types_pkg`.
- Sub-module `ram_array`: `DEPTH_W`-parameterized storage with one synchronous write port (we, index, wdata) and one asynchronous read port.
  - The latency/handshake FSM stays in `ram_access_ctrl`.

## Test plan
- Reset, then LAT=2: write 0xDEADBEEF to 0x100 held → BUSY, BUSY, ACCESS. Then read 0x100 → BUSY, BUSY, ACCESS with `ramload` = 0xDEADBEEF.
- Two-word writeback (0x200 = 0x11111111 then 0x204 = 0x22222222, address switched right after the first ACCESS) → second ACCESS exactly LAT+1 cycles after the first; both words read back correctly.
- Read of 0x300 abandoned after 1 BUSY cycle, then write to 0x300 with data 0xAAAAAAAA → count restarts (2 BUSY), no spurious write, readback = 0xAAAAAAAA.
- `RST` pulsed during the BUSY count of a write to 0x400 = 0x5 → FREE after reset, word unchanged; re-held request then completes in LAT+1 cycles.
- With `RAM_BOUNDS_CHECK_EN`: `ramaddr` = 0x8000_0000, or REN&WEN at 0x10 → ERROR every cycle, array unchanged. Without the macro: address 0x8000_0010 aliases word 0x10 → ACCESS.
- LAT=1 and LAT=15 sweeps on the same word → ACCESS at exactly t+1 and t+15.
